// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB3 master port between NUM_REQ requesters.
// Runs SETUP/ACCESS, returns read data, and aborts a transfer if the slave stalls.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT        = 15
) (
  input  logic                                pclk,
  input  logic                                preset,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ-1:0]                  i_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   i_wdata,
  output logic [NUM_REQ-1:0]                  o_done,
  output logic                                o_err,
  output logic [APB_DATA_WIDTH-1:0]           o_rdata,
  output logic                                o_psel,
  output logic                                o_penable,
  output logic                                o_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]           o_paddr,
  output logic [APB_DATA_WIDTH-1:0]           o_pwdata,
  input  logic                                i_pready,
  input  logic [APB_DATA_WIDTH-1:0]           i_prdata
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               psel_q, psel_d, penable_q, penable_d;
  logic               pwrite_q, pwrite_d, err_q, err_d;
  logic [AW-1:0]      paddr_q, paddr_d;
  logic [DW-1:0]      pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               hi_found, lo_found, grant_found;
  logic [IDX_W-1:0]   hi_idx, lo_idx, grant_idx;

  // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = NUM_REQ - 1; c >= 0; c--) begin
      if (i_req[c]) begin
        if (IDX_W'(c) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(c);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          idx_d     = grant_idx;
          last_d    = grant_idx;
          pwrite_d  = i_write[grant_idx];
          paddr_d   = i_addr[grant_idx*AW +: AW];
          pwdata_d  = i_wdata[grant_idx*DW +: DW];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (i_pready) begin
          if (!pwrite_q) rdata_d = i_prdata;
          done_d[idx_q] = 1'b1;
          err_d         = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // cnt_q counts completed stalled cycles, so this is the TIMEOUT-th ACCESS cycle.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            done_d[idx_q] = 1'b1;
            err_d         = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;
  assign o_psel    = psel_q;
  assign o_penable = penable_q;
  assign o_pwrite  = pwrite_q;
  assign o_paddr   = paddr_q;
  assign o_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus randomized
// transfers compared against a transaction-level round-robin/timeout model.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic             pclk;
  logic             preset;
  logic [NR-1:0]    i_req;
  logic [NR-1:0]    i_write;
  logic [NR*AW-1:0] i_addr;
  logic [NR*DW-1:0] i_wdata;
  logic [NR-1:0]    o_done;
  logic             o_err;
  logic [DW-1:0]    o_rdata;
  logic             o_psel;
  logic             o_penable;
  logic             o_pwrite;
  logic [AW-1:0]    o_paddr;
  logic [DW-1:0]    o_pwdata;
  logic             i_pready;
  logic [DW-1:0]    i_prdata;

  apb_master_arbiter #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset), .i_req(i_req), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_prdata(i_prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int compCount = 0;
  int errCount  = 0;

  // Transaction-level model state
  int            lastModel;
  logic [DW-1:0] modelRdata;
  logic          modelErr;
  logic [AW-1:0] modelAddr;
  logic          modelWrite;
  logic [DW-1:0] modelWdata;

  logic          writeVec [NR];
  logic [AW-1:0] addrVec  [NR];
  logic [DW-1:0] wdataVec [NR];

  int obsIdx;
  int expOrder [4] = '{0, 1, 0, 1};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int rrPick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last + k) % NR;
      if (((m >> c) & NR'(1)) != '0) return c;
    end
    return -1;
  endfunction

  task automatic driveBus();
    for (int i = 0; i < NR; i++) begin
      i_write[i]          = writeVec[i];
      i_addr[i*AW +: AW]  = addrVec[i];
      i_wdata[i*DW +: DW] = wdataVec[i];
    end
  endtask

  task automatic scrambleBus();
    for (int i = 0; i < NR; i++) begin
      writeVec[i] = 1'($urandom);
      addrVec[i]  = AW'($urandom);
      wdataVec[i] = DW'($urandom);
    end
    driveBus();
  endtask

  // One complete transfer, starting and ending just after an edge in an IDLE cycle.
  // The slave inserts 'waits' wait states; waits >= TO means it never answers.
  task automatic applyStimulus(input logic [NR-1:0] reqMask, input int waits,
                               input bit dropInSetup, input bit dropOnDone);
    int            win;
    int            doneAt;
    bit            timedOut;
    logic [DW-1:0] slaveData;
    win = rrPick(reqMask, lastModel);
    if (win < 0) return;
    modelWrite = writeVec[win];
    modelAddr  = addrVec[win];
    modelWdata = wdataVec[win];
    i_req    = reqMask;
    driveBus();
    i_pready = 1'($urandom);
    @(posedge pclk); #1;
    checkOutput("setup_psel",    32'(o_psel),    1);
    checkOutput("setup_penable", 32'(o_penable), 0);
    checkOutput("setup_done",    32'(o_done),    0);
    checkOutput("setup_paddr",   32'(o_paddr),   32'(modelAddr));
    checkOutput("setup_pwrite",  32'(o_pwrite),  32'(modelWrite));
    checkOutput("setup_pwdata",  32'(o_pwdata),  32'(modelWdata));
    scrambleBus();
    if (dropInSetup) i_req[win] = 1'b0;
    i_pready = 1'($urandom);
    @(posedge pclk); #1;
    checkOutput("access_psel",    32'(o_psel),    1);
    checkOutput("access_penable", 32'(o_penable), 1);
    timedOut  = (waits >= TO);
    doneAt    = timedOut ? TO : waits + 1;
    slaveData = DW'($urandom);
    for (int k = 1; k <= doneAt; k++) begin
      i_pready = (k > waits);
      i_prdata = (k == doneAt) ? slaveData : DW'($urandom);
      @(posedge pclk); #1;
      if (k < doneAt) begin
        checkOutput("wait_penable", 32'(o_penable), 1);
        checkOutput("wait_done",    32'(o_done),    0);
        checkOutput("wait_paddr",   32'(o_paddr),   32'(modelAddr));
        checkOutput("wait_pwdata",  32'(o_pwdata),  32'(modelWdata));
      end
    end
    i_pready = 1'($urandom);
    if (!timedOut && !modelWrite) modelRdata = slaveData;
    modelErr  = timedOut;
    lastModel = win;
    checkOutput("done_vec",     32'(o_done),    32'(NR'(1) << win));
    checkOutput("done_err",     32'(o_err),     32'(modelErr));
    checkOutput("done_rdata",   32'(o_rdata),   32'(modelRdata));
    checkOutput("done_psel",    32'(o_psel),    0);
    checkOutput("done_penable", 32'(o_penable), 0);
    checkOutput("done_paddr",   32'(o_paddr),   32'(modelAddr));
    checkOutput("done_pwrite",  32'(o_pwrite),  32'(modelWrite));
    obsIdx = -1;
    for (int i = 0; i < NR; i++) if (o_done[i]) obsIdx = i;
    if (dropOnDone) i_req[win] = 1'b0;
  endtask

  initial begin
    preset   = 1'b1;
    i_req    = '0;
    i_pready = 1'b0;
    i_prdata = '0;
    for (int i = 0; i < NR; i++) begin
      writeVec[i] = 1'b0;
      addrVec[i]  = '0;
      wdataVec[i] = '0;
    end
    driveBus();
    lastModel  = NR - 1;
    modelRdata = '0;
    modelErr   = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset_psel",    32'(o_psel),    0);
    checkOutput("reset_penable", 32'(o_penable), 0);
    checkOutput("reset_done",    32'(o_done),    0);
    checkOutput("reset_err",     32'(o_err),     0);
    checkOutput("reset_rdata",   32'(o_rdata),   0);
    checkOutput("reset_paddr",   32'(o_paddr),   0);
    preset = 1'b0;

    // Write from requester 0 with one wait state
    writeVec[0] = 1'b1; addrVec[0] = 16'h0000; wdataVec[0] = 16'hA5A5;
    applyStimulus(2'b01, 1, 1'b0, 1'b1);

    // Read from requester 1
    writeVec[1] = 1'b0; addrVec[1] = 16'h0001;
    applyStimulus(2'b10, 1, 1'b0, 1'b1);

    // Both requests held continuously: strict alternation
    for (int n = 0; n < 4; n++) begin
      writeVec[0] = 1'($urandom); writeVec[1] = 1'($urandom);
      applyStimulus(2'b11, $urandom_range(0, 2), 1'b0, 1'b0);
      checkOutput("contention_order", 32'(obsIdx), 32'(expOrder[n]));
    end
    i_req = '0;

    // Idle with stray pready: bus stays quiet and holds the last address
    i_pready = 1'b1;
    repeat (3) begin
      @(posedge pclk); #1;
      checkOutput("idle_psel",  32'(o_psel),  0);
      checkOutput("idle_done",  32'(o_done),  0);
      checkOutput("idle_paddr", 32'(o_paddr), 32'(modelAddr));
    end

    // Timeout on a read leaves rdata untouched; then a read answered on the last allowed cycle
    writeVec[0] = 1'b0; writeVec[1] = 1'b0;
    applyStimulus(2'b10, TO, 1'b0, 1'b1);
    writeVec[0] = 1'b0; writeVec[1] = 1'b0;
    applyStimulus(2'b01, TO - 1, 1'b0, 1'b1);

    // Request dropped during SETUP still completes
    writeVec[1] = 1'b1;
    applyStimulus(2'b10, 0, 1'b1, 1'b1);
    writeVec[0] = 1'b1;
    applyStimulus(2'b01, 2, 1'b1, 1'b1);

    // Reset during ACCESS aborts silently and returns priority to requester 0
    i_req    = 2'b01;
    i_pready = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    checkOutput("prereset_penable", 32'(o_penable), 1);
    preset = 1'b1;
    i_req  = '0;
    @(posedge pclk); #1;
    checkOutput("midreset_psel",    32'(o_psel),    0);
    checkOutput("midreset_penable", 32'(o_penable), 0);
    checkOutput("midreset_done",    32'(o_done),    0);
    preset     = 1'b0;
    lastModel  = NR - 1;
    modelRdata = '0;
    modelErr   = 1'b0;
    applyStimulus(2'b11, 0, 1'b0, 1'b1);
    checkOutput("postreset_grant", 32'(obsIdx), 0);
    i_req = '0;

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      int waits;
      waits = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      scrambleBus();
      applyStimulus(NR'($urandom_range(1, (1 << NR) - 1)), waits,
                    1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
